regfile_writer: RTL
===================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst_  input  1  asynchronous active-low reset; asserting it clears all state immediately, independent of clk.
REQ-003 alu_vld  input  1  ALU/CSR result offered this cycle.
REQ-004 alu_rd  input  5  destination register of the ALU result.
REQ-005 alu_data  input  32  ALU result value.
REQ-006 alu_rdy  output  1  ALU result accepted at this edge when alu_vld=1.
REQ-007 ld_issue  input  1  load issued to data memory this cycle.
REQ-008 ld_rd  input  5  destination register of the issued load.
REQ-009 ld_full  output  1  load tag queue full; ld_issue is ignored while high.
REQ-010 ld_rsp_vld  input  1  in-order load response; cannot be back-pressured.
REQ-011 ld_rsp_data  input  32  load response data.
REQ-012 wrtEn  output  1  register file write enable, registered.
REQ-013 wrtReg  output  5  register file write index, registered.
REQ-014 wrtData  output  32  register file write data, registered.
REQ-015 pend_mask  output  32  bit i=1 while any queued load targets register i; bit 0 is always 0.
REQ-016 rsp_err  output  1  sticky: a load response arrived with no load outstanding.

Function
REQ-017 Load tag queue: 4-entry in-order FIFO of ld_rd; push on ld_issue & !ld_full; pop on ld_rsp_vld & non-empty.
REQ-018 ld_full = (tag count == 4), derived from count only; a simultaneous response does not admit an issue while full.
REQ-019 ALU queue: 2-entry FIFO of {alu_rd, alu_data}; alu_rdy = (ALU count < 2), derived from count only.
REQ-020 Exactly one write candidate per cycle, priority: load response > ALU queue head > bypass of the ALU input accepted this cycle.
REQ-021 Bypass: with the ALU queue empty and no load response, an accepted ALU result goes directly to the output registers and is not enqueued.
REQ-022 Otherwise the accepted ALU result is enqueued behind the existing entries; pushing into one queue and popping from it in the same cycle is legal.
REQ-023 Output registers load the selected candidate at the posedge: wrtEn=1, wrtReg=rd, wrtData=data; with no candidate, wrtEn=0 and wrtReg/wrtData hold.
REQ-024 A candidate with rd=0 is consumed normally but drives wrtEn=0 (x0 is never written).
REQ-025 Latency: 1 cycle from the accepting edge to wrtEn high; the register file commits on the following negedge.
REQ-026 A load response with the tag queue empty sets rsp_err, is dropped, and produces no write.
REQ-027 pend_mask is combinational from valid tag entries; the bit clears in the cycle after the last load to that register is popped.
REQ-028 No reordering: writes to the same register with pend_mask set are upstream's responsibility (stall); this block retires loads in response order and ALU results in acceptance order.
REQ-029 rsp_err clears only on reset.

Reset
REQ-030 While rst_=0: both queues empty, wrtEn=0, wrtReg=0, wrtData=0, pend_mask=0, rsp_err=0, ld_full=0, alu_rdy=1.
REQ-031 Reset asserted mid-operation discards all queued entries with no write; the first edge after deassertion behaves as from empty.

Verification
REQ-032 alu_vld, rd=5, data=0xDEADBEEF, idle queues -> next cycle wrtEn=1, wrtReg=5, wrtData=0xDEADBEEF; then wrtEn=0.
REQ-033 ld_issue rd=7; two cycles later ld_rsp_vld with data=0x12345678 together with alu_vld rd=3 -> load written first (reg 7), ALU (reg 3) the next cycle; pend_mask[7] is 1 until the response, then 0.
REQ-034 Four ld_issue to regs 1,2,3,4 with no response -> ld_full=1, a 5th issue is ignored; four responses retire regs 1..4 in order.
REQ-035 Continuous load responses with alu_vld held -> alu_rdy drops after 2 accepts; queued ALU results drain in order once responses stop.
REQ-036 alu_vld rd=0 -> wrtEn stays 0; ld_rsp_vld with no outstanding load -> rsp_err=1, no write.
REQ-037 Assert rst_ with 2 ALU entries and 3 loads queued -> all outputs return to reset values immediately; no write follows deassertion.

Source files
------------

// File: rtl/regfile_writer.sv
// ---------------------------------------------------------------------------
// regfile_writer
//
// Purpose:
//   Merges two producers of register-file writes into one registered write
//   port. ALU/CSR results are accepted through a valid/ready handshake.
//   Load data comes back from memory in order and cannot be stalled.
//   Destination tags of issued loads are queued so that each response can be
//   matched to its register.
//
// Ports:
//   clk          in   1   clock; all state updates on the rising edge
//   rst_         in   1   asynchronous active-low reset
//   alu_vld      in   1   ALU/CSR result offered this cycle
//   alu_rd       in   5   destination register of the ALU result
//   alu_data     in  32   ALU result value
//   alu_rdy      out  1   ALU result accepted at this edge when alu_vld=1
//   ld_issue     in   1   load issued to data memory this cycle
//   ld_rd        in   5   destination register of the issued load
//   ld_full      out  1   load tag queue full; ld_issue ignored while high
//   ld_rsp_vld   in   1   in-order load response (no back-pressure)
//   ld_rsp_data  in  32   load response data
//   wrtEn        out  1   register file write enable (registered)
//   wrtReg       out  5   register file write index (registered)
//   wrtData      out 32   register file write data (registered)
//   pend_mask    out 32   bit i set while a queued load targets register i
//   rsp_err      out  1   sticky: load response with nothing outstanding
// ---------------------------------------------------------------------------
module regfile_writer (
  input  logic        clk,
  input  logic        rst_,
  input  logic        alu_vld,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_rdy,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_full,
  input  logic        ld_rsp_vld,
  input  logic [31:0] ld_rsp_data,
  output logic        wrtEn,
  output logic [4:0]  wrtReg,
  output logic [31:0] wrtData,
  output logic [31:0] pend_mask,
  output logic        rsp_err
);

  localparam int TAG_DEPTH = 4;
  localparam int ALU_DEPTH = 2;

  // Load tag queue storage: circular buffer with a head pointer and count.
  logic [4:0]  r_tagMem [TAG_DEPTH];
  logic [1:0]  r_tagHead;
  logic [2:0]  r_tagCnt;

  // ALU queue storage: each entry is {rd, data}.
  logic [36:0] r_aluMem [ALU_DEPTH];
  logic        r_aluHead;
  logic [1:0]  r_aluCnt;

  // Registered write port and sticky error flag.
  logic        r_wrtEn;
  logic [4:0]  r_wrtReg;
  logic [31:0] r_wrtData;
  logic        r_rspErr;

  // Handshake and queue control.
  logic        w_tagPush;
  logic        w_tagPop;
  logic        w_rspErr;
  logic [1:0]  w_tagTail;
  logic        w_aluAcc;
  logic        w_aluHeadPop;
  logic        w_aluBypass;
  logic        w_aluPush;
  logic        w_aluTail;

  // Selected write candidate.
  logic        w_candVld;
  logic [4:0]  w_candRd;
  logic [31:0] w_candData;

  logic [31:0] w_pendMask;

  // Full/ready depend on the stored counts only, so a response or a head pop
  // in the same cycle never opens a slot early.
  assign ld_full = (r_tagCnt == 3'(TAG_DEPTH));
  assign alu_rdy = (r_aluCnt < 2'(ALU_DEPTH));

  assign w_tagPush = ld_issue & ~ld_full;
  assign w_tagPop  = ld_rsp_vld & (r_tagCnt != 3'd0);
  assign w_rspErr  = ld_rsp_vld & (r_tagCnt == 3'd0);
  assign w_tagTail = r_tagHead + r_tagCnt[1:0];

  assign w_aluAcc  = alu_vld & alu_rdy;
  assign w_aluTail = r_aluHead + r_aluCnt[0];

  // Candidate selection: a valid load response always wins because it cannot
  // wait; otherwise the oldest queued ALU result goes; only with an empty ALU
  // queue may the incoming ALU result skip the queue and write directly.
  always_comb begin
    w_candVld    = 1'b0;
    w_candRd     = 5'd0;
    w_candData   = 32'd0;
    w_aluHeadPop = 1'b0;
    w_aluBypass  = 1'b0;
    if (w_tagPop) begin
      w_candVld  = 1'b1;
      w_candRd   = r_tagMem[r_tagHead];
      w_candData = ld_rsp_data;
    end else if (r_aluCnt != 2'd0) begin
      w_candVld    = 1'b1;
      w_aluHeadPop = 1'b1;
      w_candRd     = r_aluMem[r_aluHead][36:32];
      w_candData   = r_aluMem[r_aluHead][31:0];
    end else if (w_aluAcc) begin
      w_candVld   = 1'b1;
      w_aluBypass = 1'b1;
      w_candRd    = alu_rd;
      w_candData  = alu_data;
    end
  end

  assign w_aluPush = w_aluAcc & ~w_aluBypass;

  // Load tag queue: push at the tail computed from the pre-edge state, so a
  // simultaneous push and pop keeps the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tagMem[i] <= 5'd0;
      end
      r_tagHead <= 2'd0;
      r_tagCnt  <= 3'd0;
    end else begin
      if (w_tagPush) begin
        r_tagMem[w_tagTail] <= ld_rd;
      end
      if (w_tagPop) begin
        r_tagHead <= r_tagHead + 2'd1;
      end
      case ({w_tagPush, w_tagPop})
        2'b10:   r_tagCnt <= r_tagCnt + 3'd1;
        2'b01:   r_tagCnt <= r_tagCnt - 3'd1;
        default: r_tagCnt <= r_tagCnt;
      endcase
    end
  end

  // ALU queue: an accepted result that did not bypass lands behind the
  // existing entries, even when the head leaves in the same cycle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < ALU_DEPTH; i++) begin
        r_aluMem[i] <= 37'd0;
      end
      r_aluHead <= 1'b0;
      r_aluCnt  <= 2'd0;
    end else begin
      if (w_aluPush) begin
        r_aluMem[w_aluTail] <= {alu_rd, alu_data};
      end
      if (w_aluHeadPop) begin
        r_aluHead <= ~r_aluHead;
      end
      case ({w_aluPush, w_aluHeadPop})
        2'b10:   r_aluCnt <= r_aluCnt + 2'd1;
        2'b01:   r_aluCnt <= r_aluCnt - 2'd1;
        default: r_aluCnt <= r_aluCnt;
      endcase
    end
  end

  // Output registers: a candidate for x0 is consumed but never asserts the
  // enable; with no candidate, index and data hold their last values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_wrtEn   <= 1'b0;
      r_wrtReg  <= 5'd0;
      r_wrtData <= 32'd0;
    end else if (w_candVld) begin
      r_wrtEn   <= (w_candRd != 5'd0);
      r_wrtReg  <= w_candRd;
      r_wrtData <= w_candData;
    end else begin
      r_wrtEn   <= 1'b0;
    end
  end

  // A response with no load outstanding is dropped and latches the error
  // until the next reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rspErr <= 1'b0;
    end else if (w_rspErr) begin
      r_rspErr <= 1'b1;
    end
  end

  // Pending mask: OR of the one-hot destinations of all valid tag entries.
  always_comb begin
    w_pendMask = 32'd0;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      if (3'(i) < r_tagCnt) begin
        w_pendMask[r_tagMem[r_tagHead + 2'(i)]] = 1'b1;
      end
    end
    w_pendMask[0] = 1'b0;
  end

  assign pend_mask = w_pendMask;
  assign wrtEn     = r_wrtEn;
  assign wrtReg    = r_wrtReg;
  assign wrtData   = r_wrtData;
  assign rsp_err   = r_rspErr;

endmodule
